demux32_reg: RTL and testbench

Write-side counterpart of the 32:1 read mux: a 1-to-32 demultiplexing register bank. A single write port steers an N-bit word into one of 32 output registers selected by a 5-bit index. A per-entry valid mask and a sequential clear sweep are included. Together with the existing 32:1 mux on the read side, it forms the register storage behind the ALU datapath.

---
 rtl/demux32_reg.sv | 147 ++++++++++++++
 tb/tb_demux32_reg.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux32_reg.sv
// 1-to-32 demultiplexing register bank with per-entry valid mask and a
// sequential clear sweep; rd_data is the combinational 32:1 readback mux.
module demux32_reg #(
    parameter int unsigned N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_ena,
    input  logic [4:0]       wr_sel,
    input  logic [N-1:0]     wr_data,
    input  logic             clr,
    input  logic [4:0]       rd_sel,
    output logic [N-1:0]     q00,
    output logic [N-1:0]     q01,
    output logic [N-1:0]     q02,
    output logic [N-1:0]     q03,
    output logic [N-1:0]     q04,
    output logic [N-1:0]     q05,
    output logic [N-1:0]     q06,
    output logic [N-1:0]     q07,
    output logic [N-1:0]     q08,
    output logic [N-1:0]     q09,
    output logic [N-1:0]     q10,
    output logic [N-1:0]     q11,
    output logic [N-1:0]     q12,
    output logic [N-1:0]     q13,
    output logic [N-1:0]     q14,
    output logic [N-1:0]     q15,
    output logic [N-1:0]     q16,
    output logic [N-1:0]     q17,
    output logic [N-1:0]     q18,
    output logic [N-1:0]     q19,
    output logic [N-1:0]     q20,
    output logic [N-1:0]     q21,
    output logic [N-1:0]     q22,
    output logic [N-1:0]     q23,
    output logic [N-1:0]     q24,
    output logic [N-1:0]     q25,
    output logic [N-1:0]     q26,
    output logic [N-1:0]     q27,
    output logic [N-1:0]     q28,
    output logic [N-1:0]     q29,
    output logic [N-1:0]     q30,
    output logic [N-1:0]     q31,
    output logic [31:0]      valid,
    output logic             busy,
    output logic [N-1:0]     rd_data
);

    localparam int unsigned NUM_ENT = 32;
    localparam int unsigned SEL_W   = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [SEL_W-1:0]       cnt_q, cnt_d;
    logic [N-1:0]           q_q [NUM_ENT];
    logic [N-1:0]           q_d [NUM_ENT];
    logic [NUM_ENT-1:0]     valid_q, valid_d;
    logic                   busy_q, busy_d;

    // Next state: clr beats wr_ena in IDLE; SWEEP ignores both inputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end else if (wr_ena) begin
                    q_d[wr_sel]     = wr_data;
                    valid_d[wr_sel] = 1'b1;
                end
            end
            SWEEP: begin
                q_d[cnt_q]     = '0;
                valid_d[cnt_q] = 1'b0;
                cnt_d          = cnt_q + SEL_W'(1);
                if (cnt_q == SEL_W'(NUM_ENT - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SWEEP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '{default: '0};
            valid_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign valid   = valid_q;
    assign busy    = busy_q;
    assign rd_data = q_q[rd_sel];

    assign q00 = q_q[0];
    assign q01 = q_q[1];
    assign q02 = q_q[2];
    assign q03 = q_q[3];
    assign q04 = q_q[4];
    assign q05 = q_q[5];
    assign q06 = q_q[6];
    assign q07 = q_q[7];
    assign q08 = q_q[8];
    assign q09 = q_q[9];
    assign q10 = q_q[10];
    assign q11 = q_q[11];
    assign q12 = q_q[12];
    assign q13 = q_q[13];
    assign q14 = q_q[14];
    assign q15 = q_q[15];
    assign q16 = q_q[16];
    assign q17 = q_q[17];
    assign q18 = q_q[18];
    assign q19 = q_q[19];
    assign q20 = q_q[20];
    assign q21 = q_q[21];
    assign q22 = q_q[22];
    assign q23 = q_q[23];
    assign q24 = q_q[24];
    assign q25 = q_q[25];
    assign q26 = q_q[26];
    assign q27 = q_q[27];
    assign q28 = q_q[28];
    assign q29 = q_q[29];
    assign q30 = q_q[30];
    assign q31 = q_q[31];

endmodule

// File: tb/tb_demux32_reg.sv
// Randomized and directed bench for demux32_reg against a behavioural model
// of the bank (array of words, valid mask, remaining-sweep-cycles counter).
module tb_demux32_reg;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_ena;
    logic [4:0]   wr_sel;
    logic [N-1:0] wr_data;
    logic         clr;
    logic [4:0]   rd_sel;
    wire  [N-1:0] dq [32];
    wire  [31:0]  valid;
    wire          busy;
    wire  [N-1:0] rd_data;

    logic [N-1:0] mq [32];
    logic [31:0]  mvalid;
    int           sweep_left;
    int           n_vec = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    demux32_reg #(.N(N)) dut (
        .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_sel(wr_sel), .wr_data(wr_data),
        .clr(clr), .rd_sel(rd_sel),
        .q00(dq[0]),  .q01(dq[1]),  .q02(dq[2]),  .q03(dq[3]),
        .q04(dq[4]),  .q05(dq[5]),  .q06(dq[6]),  .q07(dq[7]),
        .q08(dq[8]),  .q09(dq[9]),  .q10(dq[10]), .q11(dq[11]),
        .q12(dq[12]), .q13(dq[13]), .q14(dq[14]), .q15(dq[15]),
        .q16(dq[16]), .q17(dq[17]), .q18(dq[18]), .q19(dq[19]),
        .q20(dq[20]), .q21(dq[21]), .q22(dq[22]), .q23(dq[23]),
        .q24(dq[24]), .q25(dq[25]), .q26(dq[26]), .q27(dq[27]),
        .q28(dq[28]), .q29(dq[29]), .q30(dq[30]), .q31(dq[31]),
        .valid(valid), .busy(busy), .rd_data(rd_data)
    );

    // One rising edge: advance the model with the inputs the DUT sampled.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 32; k++) mq[k] = '0;
            mvalid     = '0;
            sweep_left = 0;
        end else if (sweep_left > 0) begin
            mq[32 - sweep_left]     = '0;
            mvalid[32 - sweep_left] = 1'b0;
            sweep_left--;
        end else if (clr) begin
            sweep_left = 32;
        end else if (wr_ena) begin
            mq[wr_sel]     = wr_data;
            mvalid[wr_sel] = 1'b1;
        end
        #1;
    endtask

    task automatic fill(input logic [N-1:0] val);
        wr_ena = 1'b1;
        wr_data = val;
        for (int k = 0; k < 32; k++) begin
            wr_sel = 5'(k);
            step();
        end
        wr_ena = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            wr_ena  = 1'($urandom);
            clr     = 1'($urandom);
            wr_sel  = 5'($urandom);
            wr_data = N'($urandom);
            rd_sel  = 5'($urandom);
            step();
        end
        rst = 1'b0; wr_ena = 1'b0; clr = 1'b0;
        #1;
        for (int k = 0; k < 32; k++) begin
            n_vec++;
            if (dq[k] !== '0) begin n_err++; $display("FAIL reset q%0d got %h exp 0", k, dq[k]); end
        end
        n_vec++;
        if (valid !== 32'h0) begin n_err++; $display("FAIL reset valid got %h exp 0", valid); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy got %b exp 0", busy); end
        n_vec++;
        if (rd_data !== '0) begin n_err++; $display("FAIL reset rd_data got %h exp 0", rd_data); end
    endtask

    task automatic test_write_readback();
        wr_ena = 1'b1;
        wr_sel = 5'd0;  wr_data = 4'hA; step();
        wr_sel = 5'd17; wr_data = 4'h5; step();
        wr_sel = 5'd31; wr_data = 4'hF; step();
        wr_ena = 1'b0;
        n_vec++;
        if (dq[17] !== 4'h5) begin n_err++; $display("FAIL wr q17 got %h exp 5", dq[17]); end
        n_vec++;
        if (valid !== 32'h8002_0001) begin n_err++; $display("FAIL wr valid got %h exp 80020001", valid); end
        rd_sel = 5'd31; #1;
        n_vec++;
        if (rd_data !== 4'hF) begin n_err++; $display("FAIL wr rd31 got %h exp f", rd_data); end
        rd_sel = 5'd3; #1;
        n_vec++;
        if (rd_data !== 4'h0) begin n_err++; $display("FAIL wr rd3 got %h exp 0", rd_data); end
    endtask

    task automatic test_overwrite();
        wr_ena = 1'b1; wr_sel = 5'd9;
        wr_data = 4'h3; step();
        wr_data = 4'h0; step();
        wr_ena = 1'b0;
        n_vec++;
        if (dq[9] !== 4'h0) begin n_err++; $display("FAIL ovw q09 got %h exp 0", dq[9]); end
        n_vec++;
        if (valid[9] !== 1'b1) begin n_err++; $display("FAIL ovw valid9 got %b exp 1", valid[9]); end
    endtask

    task automatic test_clear_sweep();
        fill(4'h7);
        clr = 1'b1; step(); clr = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL sweep busy@t got %b exp 1", busy); end
        for (int e = 1; e <= 32; e++) begin
            step();
            n_vec++;
            if (busy !== (e < 32)) begin
                n_err++; $display("FAIL sweep busy@t+%0d got %b exp %b", e, busy, e < 32);
            end
            if (e == 5) begin
                for (int k = 0; k <= 5; k++) begin
                    n_vec++;
                    if (dq[k] !== ((k < 5) ? 4'h0 : 4'h7)) begin
                        n_err++; $display("FAIL sweep t+5 q%0d got %h", k, dq[k]);
                    end
                end
            end
        end
        for (int k = 0; k < 32; k++) begin
            n_vec++;
            if (dq[k] !== 4'h0) begin n_err++; $display("FAIL sweep end q%0d got %h exp 0", k, dq[k]); end
        end
        n_vec++;
        if (valid !== 32'h0) begin n_err++; $display("FAIL sweep end valid got %h exp 0", valid); end
    endtask

    task automatic test_collisions();
        int hi;
        clr = 1'b1; wr_ena = 1'b1; wr_sel = 5'($urandom); wr_data = 4'hC;
        step();
        clr = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL coll busy got %b exp 1", busy); end
        n_vec++;
        if (dq[wr_sel] !== mq[wr_sel]) begin
            n_err++; $display("FAIL coll dropped q%0d got %h exp %h", wr_sel, dq[wr_sel], mq[wr_sel]);
        end
        n_vec++;
        if (valid !== mvalid) begin n_err++; $display("FAIL coll valid got %h exp %h", valid, mvalid); end
        wr_sel = 5'd20; wr_data = 4'h9;
        hi = 0;
        for (int e = 0; e < 40 && busy; e++) begin
            hi++;
            clr = (hi == 15);
            step();
        end
        clr = 1'b0; wr_ena = 1'b0;
        n_vec++;
        if (hi != 32) begin n_err++; $display("FAIL coll busy_len got %0d exp 32", hi); end
        n_vec++;
        if (dq[20] !== 4'h0) begin n_err++; $display("FAIL coll q20 got %h exp 0", dq[20]); end
        n_vec++;
        if (valid !== mvalid) begin n_err++; $display("FAIL coll end valid got %h exp %h", valid, mvalid); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wr_ena  = 1'($urandom);
            clr     = ($urandom_range(0, 49) == 0);
            wr_sel  = 5'($urandom);
            wr_data = N'($urandom);
            step();
            rd_sel  = 5'($urandom);
            #1;
            for (int k = 0; k < 32; k++) begin
                n_vec++;
                if (dq[k] !== mq[k]) begin
                    n_err++; $display("FAIL rand c%0d q%0d got %h exp %h", c, k, dq[k], mq[k]);
                end
            end
            n_vec++;
            if (valid !== mvalid) begin n_err++; $display("FAIL rand c%0d valid got %h exp %h", c, valid, mvalid); end
            n_vec++;
            if (busy !== (sweep_left > 0)) begin
                n_err++; $display("FAIL rand c%0d busy got %b exp %b", c, busy, sweep_left > 0);
            end
            n_vec++;
            if (rd_data !== mq[rd_sel]) begin
                n_err++; $display("FAIL rand c%0d rd_data got %h exp %h", c, rd_data, mq[rd_sel]);
            end
        end
        wr_ena = 1'b0; clr = 1'b0;
        for (int c = 0; c < 34; c++) step();
    endtask

    task automatic test_reset_mid_sweep();
        fill(4'h7);
        clr = 1'b1; step(); clr = 1'b0;
        for (int e = 1; e <= 10; e++) step();
        n_vec++;
        if (dq[9] !== 4'h0 || dq[11] !== 4'h7) begin
            n_err++; $display("FAIL rstmid pre q09=%h q11=%h exp 0/7", dq[9], dq[11]);
        end
        rst = 1'b1; step(); rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            n_vec++;
            if (dq[k] !== 4'h0) begin n_err++; $display("FAIL rstmid q%0d got %h exp 0", k, dq[k]); end
        end
        n_vec++;
        if (valid !== 32'h0) begin n_err++; $display("FAIL rstmid valid got %h exp 0", valid); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid busy got %b exp 0", busy); end
        wr_ena = 1'b1; wr_sel = 5'd0; wr_data = 4'h2; step(); wr_ena = 1'b0;
        n_vec++;
        if (dq[0] !== 4'h2) begin n_err++; $display("FAIL rstmid wr q00 got %h exp 2", dq[0]); end
        n_vec++;
        if (valid !== 32'h1) begin n_err++; $display("FAIL rstmid wr valid got %h exp 1", valid); end
    endtask

    initial begin
        rst = 1'b1; wr_ena = 1'b0; clr = 1'b0;
        wr_sel = '0; wr_data = '0; rd_sel = '0;
        mvalid = '0; sweep_left = 0;
        for (int k = 0; k < 32; k++) mq[k] = '0;
        test_reset();
        test_write_readback();
        test_overwrite();
        test_clear_sweep();
        test_collisions();
        test_random();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
